// File: rtl/countdown_pkg.sv
// Shared encodings for the countdown timer control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The state encoding is visible on the debug LEDs, so these values are fixed.
// Values 3'd5..3'd7 are never produced; the sequencer recovers from them to IDLE.
package countdown_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The counter follows the preset in these states.
    function automatic logic is_load_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_SET);
    endfunction

endpackage

// File: rtl/countdown_sequencer_tick_counter.sv
// Tick counter with sync clear; term flags the last count of an N-tick window.
// Latency: count updates 1 cycle after a tick; term is decoded from the register.
// Backpressure: none; every tick_in pulse is counted unless clr is asserted.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clr         synchronous clear (wins over tick_in)
//   tick_in     count enable, one pulse per tick
//   term        count register currently holds N-1
module tick_counter #(
    parameter int N = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick_in,
    output logic term
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_in) begin
            // Wrap so a missed clear can never run the counter past the window.
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == LAST);

endmodule

// File: rtl/countdown_sequencer.sv
// Control FSM for the 1 Hz countdown timer: preset register, counter load/enable, done flash.
// Latency: state/preset/blank change 1 cycle after an event; count_en is combinational on tick.
// Backpressure: none; one-pulse inputs are acted on in the cycle they arrive or dropped.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   tick         1 Hz single-cycle pulse
//   start_p      start / pause / acknowledge button pulse
//   set_p        set-mode button pulse
//   inc_p        preset increment button pulse (SET only)
//   clr_p        soft clear, returns to IDLE keeping the preset
//   cnt_zero     down counter is at zero
//   load         counter should load load_value (level, IDLE and SET)
//   load_value   current preset
//   count_en     counter decrements this cycle
//   blank        display blanking, toggles while flashing in DONE
//   done         high while in DONE
//   state_o      raw state register for debug LEDs
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int W          = 6,
    parameter int MAX_PRESET = 59,
    parameter int DEF_PRESET = 30,
    parameter int DONE_TICKS = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         start_p,
    input  logic         set_p,
    input  logic         inc_p,
    input  logic         clr_p,
    input  logic         cnt_zero,
    output logic         load,
    output logic [W-1:0] load_value,
    output logic         count_en,
    output logic         blank,
    output logic         done,
    output logic [2:0]   state_o
);

    localparam logic [W-1:0] MAX_P = W'(MAX_PRESET);
    localparam logic [W-1:0] DEF_P = W'(DEF_PRESET);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   preset_q;
    logic [W-1:0]   preset_d;
    logic           blank_q;
    logic           blank_d;

    logic           flash_clr;
    logic           flash_tick;
    logic           flash_last;

    // ------------------------------------------------------------------
    // Flash window: counts ticks spent in DONE. Held clear whenever we are
    // not in DONE or are about to leave it, so every entry starts at zero.
    // ------------------------------------------------------------------
    assign flash_clr  = (state_q != ST_DONE) || (state_d != ST_DONE);
    assign flash_tick = (state_q == ST_DONE) && tick;

    tick_counter #(
        .N       (DONE_TICKS)
    ) u_flash_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flash_clr),
        .tick_in (flash_tick),
        .term    (flash_last)
    );

    // ------------------------------------------------------------------
    // Next-state, preset and blank logic.
    // Within each state the if/else order gives the event priority;
    // clr_p is applied last so it overrides everything.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        blank_d  = blank_q;

        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d = (preset_q != '0) ? ST_RUN : ST_DONE;
                end else if (set_p) begin
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                if (start_p) begin
                    state_d = (preset_q != '0) ? ST_RUN : ST_DONE;
                end else if (set_p) begin
                    state_d = ST_IDLE;
                end else if (inc_p) begin
                    preset_d = (preset_q == MAX_P) ? '0 : preset_q + 1'b1;
                end
            end

            ST_RUN: begin
                // set_p / inc_p deliberately ignored while counting.
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else if (start_p) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (start_p) begin
                    state_d = ST_RUN;
                end else if (set_p) begin
                    // Abort: IDLE drives load, so the counter snaps back to the preset.
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (start_p) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (flash_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        blank_d = ~blank_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clr_p) begin
            state_d  = ST_IDLE;
            preset_d = preset_q;
        end

        // Blank only lives inside one DONE visit: cleared on entry and exit.
        if ((state_q != ST_DONE) || (state_d != ST_DONE)) begin
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            preset_q <= DEF_P;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            blank_q  <= blank_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. count_en is combinational so the tick is consumed in the
    // cycle it arrives; a tick landing on the start_p that enters RUN is
    // not counted because state_q is not yet RUN.
    // ------------------------------------------------------------------
    assign load       = is_load_state(state_q);
    assign load_value = preset_q;
    assign count_en   = (state_q == ST_RUN) && tick && !cnt_zero;
    assign blank      = blank_q;
    assign done       = (state_q == ST_DONE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
module tb_countdown_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start_p;
    logic       set_p;
    logic       inc_p;
    logic       clr_p;
    logic       cnt_zero;
    logic       load;
    logic [5:0] load_value;
    logic       count_en;
    logic       blank;
    logic       done;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of expected values, pushed when stimulus is issued.
    int exp_q[$];

    logic       cen_seen;
    logic [5:0] mdl_cnt;   // environment: the down counter the sequencer drives

    countdown_sequencer #(
        .W          (6),
        .MAX_PRESET (59),
        .DEF_PRESET (30),
        .DONE_TICKS (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_p    (start_p),
        .set_p      (set_p),
        .inc_p      (inc_p),
        .clr_p      (clr_p),
        .cnt_zero   (cnt_zero),
        .load       (load),
        .load_value (load_value),
        .count_en   (count_en),
        .blank      (blank),
        .done       (done),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl_cnt <= 6'd0;
        else if (load) mdl_cnt <= load_value;
        else if (count_en && mdl_cnt != 6'd0) mdl_cnt <= mdl_cnt - 6'd1;
    end
    assign cnt_zero = (mdl_cnt == 6'd0);

    // One cycle of stimulus: inputs applied at negedge, count_en captured
    // mid-cycle, registered outputs settle 1 time unit after the posedge.
    task automatic drive(input logic s, input logic se, input logic i,
                         input logic c, input logic t);
        @(negedge clk);
        start_p = s; set_p = se; inc_p = i; clr_p = c; tick = t;
        #1 cen_seen = count_en;
        @(posedge clk);
        #1;
        start_p = 0; set_p = 0; inc_p = 0; clr_p = 0; tick = 0;
    endtask

    // Stimulus only: from IDLE with preset 3, count out and enter DONE.
    task automatic run_to_done();
        drive(1, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; tick = 0; start_p = 0; set_p = 0; inc_p = 0; clr_p = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (load !== 1'b1) begin n_errors++; $display("FAIL reset_load: got %b expected 1", load); end
        n_checks++; if (load_value !== 6'd30) begin n_errors++; $display("FAIL reset_load_value: got %0d expected 30", load_value); end
        n_checks++; if (count_en !== 1'b0) begin n_errors++; $display("FAIL reset_count_en: got %b expected 0", count_en); end
        n_checks++; if (blank !== 1'b0) begin n_errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (state_o !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        rst_n = 1;
        drive(0, 0, 0, 0, 1);
        n_checks++; if (state_o !== 3'd0 || load_value !== 6'd30) begin
            n_errors++; $display("FAIL post_reset_idle: got state %0d value %0d expected 0 30", state_o, load_value); end
    endtask

    task automatic test_set_wrap();
        int model;
        drive(0, 1, 0, 0, 0);
        n_checks++; if (state_o !== 3'd1 || load !== 1'b1) begin
            n_errors++; $display("FAIL enter_set: got state %0d load %b expected 1 1", state_o, load); end
        model = 30;
        for (int i = 0; i < 30; i++) begin
            model = (model == 59) ? 0 : model + 1;
            exp_q.push_back(model);
            drive(0, 0, 1, 0, 0);
            model = exp_q.pop_front();
            n_checks++; if (load_value !== 6'(model)) begin
                n_errors++; $display("FAIL inc_%0d: got %0d expected %0d", i, load_value, model); end
        end
        drive(0, 1, 0, 0, 0);
        n_checks++; if (state_o !== 3'd0) begin n_errors++; $display("FAIL set_exit: got %0d expected 0", state_o); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd4 || done !== 1'b1 || load !== 1'b0) begin
            n_errors++; $display("FAIL zero_start_done: got state %0d done %b load %b expected 4 1 0", state_o, done, load); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd0) begin n_errors++; $display("FAIL done_ack: got %0d expected 0", state_o); end
    endtask

    task automatic test_run_count();
        int rem;
        drive(0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        n_checks++; if (load_value !== 6'd3 || state_o !== 3'd0) begin
            n_errors++; $display("FAIL preset3: got %0d state %0d expected 3 0", load_value, state_o); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd2 || cen_seen !== 1'b0) begin
            n_errors++; $display("FAIL run_entry: got state %0d cen %b expected 2 0", state_o, cen_seen); end
        for (int k = 2; k >= 0; k--) exp_q.push_back(k);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (cen_seen !== 1'b1) begin
                n_errors++; $display("FAIL run_pulse_%0d: got count_en %b expected 1", k, cen_seen);
                void'(exp_q.pop_front());
            end else begin
                rem = exp_q.pop_front();
                if (mdl_cnt !== 6'(rem)) begin
                    n_errors++; $display("FAIL run_remaining_%0d: got %0d expected %0d", k, mdl_cnt, rem); end
            end
        end
        n_checks++; if (state_o !== 3'd2) begin n_errors++; $display("FAIL run_at_zero: got %0d expected 2", state_o); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if (cen_seen !== 1'b0) begin n_errors++; $display("FAIL zero_no_count: got %b expected 0", cen_seen); end
        n_checks++; if (state_o !== 3'd4 || done !== 1'b1 || blank !== 1'b0) begin
            n_errors++; $display("FAIL enter_done: got state %0d done %b blank %b expected 4 1 0", state_o, done, blank); end
    endtask

    task automatic test_done_flash(input string tag);
        int exp_b;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 1);
            exp_b = exp_q.pop_front();
            n_checks++; if (blank !== 1'(exp_b) || state_o !== 3'd4) begin
                n_errors++; $display("FAIL %s_blank_%0d: got blank %b state %0d expected %0d 4", tag, k, blank, state_o, exp_b); end
            drive(0, 0, 0, 0, 0);
            n_checks++; if (blank !== 1'(exp_b)) begin
                n_errors++; $display("FAIL %s_hold_%0d: got %b expected %0d", tag, k, blank, exp_b); end
        end
        drive(0, 0, 0, 0, 1);
        n_checks++; if (state_o !== 3'd0 || blank !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL %s_exit: got state %0d blank %b done %b expected 0 0 0", tag, state_o, blank, done); end
    endtask

    task automatic test_pause();
        drive(1, 0, 0, 0, 1);
        n_checks++; if (state_o !== 3'd2 || cen_seen !== 1'b0) begin
            n_errors++; $display("FAIL start_tick: got state %0d cen %b expected 2 0", state_o, cen_seen); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if (cen_seen !== 1'b1 || mdl_cnt !== 6'd2) begin
            n_errors++; $display("FAIL first_tick: got cen %b cnt %0d expected 1 2", cen_seen, mdl_cnt); end
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        n_checks++; if (state_o !== 3'd2 || load_value !== 6'd3) begin
            n_errors++; $display("FAIL run_ignores_set: got state %0d value %0d expected 2 3", state_o, load_value); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd3) begin n_errors++; $display("FAIL pause: got %0d expected 3", state_o); end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++; if (cen_seen !== 1'b0 || state_o !== 3'd3) begin
                n_errors++; $display("FAIL pause_tick_%0d: got cen %b state %0d expected 0 3", k, cen_seen, state_o); end
        end
        n_checks++; if (mdl_cnt !== 6'd2) begin n_errors++; $display("FAIL pause_frozen: got %0d expected 2", mdl_cnt); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd2) begin n_errors++; $display("FAIL resume: got %0d expected 2", state_o); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if (cen_seen !== 1'b1 || mdl_cnt !== 6'd1) begin
            n_errors++; $display("FAIL resume_tick: got cen %b cnt %0d expected 1 1", cen_seen, mdl_cnt); end
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        n_checks++; if (state_o !== 3'd0 || load !== 1'b1) begin
            n_errors++; $display("FAIL pause_abort: got state %0d load %b expected 0 1", state_o, load); end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (mdl_cnt !== 6'd3) begin n_errors++; $display("FAIL abort_reload: got %0d expected 3", mdl_cnt); end
    endtask

    task automatic test_clr();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        n_checks++; if (state_o !== 3'd0 || blank !== 1'b0 || load_value !== 6'd3) begin
            n_errors++; $display("FAIL clr_over_start: got state %0d blank %b value %0d expected 0 0 3", state_o, blank, load_value); end
    endtask

    task automatic test_back_to_back();
        run_to_done();
        repeat (3) drive(0, 0, 0, 0, 1);
        n_checks++; if (blank !== 1'b1) begin n_errors++; $display("FAIL partial_flash: got %b expected 1", blank); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd0 || blank !== 1'b0) begin
            n_errors++; $display("FAIL done_start_exit: got state %0d blank %b expected 0 0", state_o, blank); end
        run_to_done();
        n_checks++; if (state_o !== 3'd4 || blank !== 1'b0) begin
            n_errors++; $display("FAIL reenter_done: got state %0d blank %b expected 4 0", state_o, blank); end
        test_done_flash("reentry");
    endtask

    task automatic test_reset_mid_run();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_checks++; if (state_o !== 3'd2) begin n_errors++; $display("FAIL pre_reset_run: got %0d expected 2", state_o); end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_checks++; if (state_o !== 3'd0 || load !== 1'b1 || load_value !== 6'd30 ||
                         count_en !== 1'b0 || blank !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL async_reset: got state %0d load %b value %0d cen %b blank %b done %b expected 0 1 30 0 0 0",
                                 state_o, load, load_value, count_en, blank, done); end
        @(negedge clk);
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
        n_checks++; if (state_o !== 3'd0 || load_value !== 6'd30) begin
            n_errors++; $display("FAIL after_async_reset: got state %0d value %0d expected 0 30", state_o, load_value); end
    endtask

    initial begin
        test_reset();
        test_set_wrap();
        test_run_count();
        test_done_flash("flash");
        test_pause();
        test_clr();
        test_back_to_back();
        test_reset_mid_run();
        n_checks++; if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
